// File: rtl/vga_pkg.sv
// Default 640x480@60 Hz VGA timing constants shared by the sync generator.
// Counter width of 11 bits covers line/frame totals up to 2047.
package vga_pkg;
  localparam int CNT_W = 11;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam logic VGA_HS_POL = 1'b0;
  localparam logic VGA_VS_POL = 1'b0;
endpackage

// File: rtl/vga_pix_div.sv
// Pixel clock-enable: registered one-clk pulse every CLK_DIV system clocks.
// Low in reset; with CLK_DIV = 1 it is high on every cycle after reset.
module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
  end

  // Tick is registered from the next count so it lines up with div_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= (div_cnt_d == DIV_LAST);
    end
  end

  assign pix_tick_o = tick_q;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, visible-area and sync decode, strobes.
// Decode is registered from next counter values so it never lags hc/vc.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV = 4,
  parameter int   H_VIS   = VGA_H_VIS,
  parameter int   H_FP    = VGA_H_FP,
  parameter int   H_SYNC  = VGA_H_SYNC,
  parameter int   H_BP    = VGA_H_BP,
  parameter int   V_VIS   = VGA_V_VIS,
  parameter int   V_FP    = VGA_V_FP,
  parameter int   V_SYNC  = VGA_V_SYNC,
  parameter int   V_BP    = VGA_V_BP,
  parameter logic HS_POL  = VGA_HS_POL,
  parameter logic VS_POL  = VGA_VS_POL
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             vidon,
  output logic             hsync,
  output logic             vsync,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic             tick;
  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic             vidon_q, hsync_q, vsync_q, line_start_q, frame_start_q;
  logic             h_wrap, v_wrap;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_tick_o(tick)
  );

  always_comb begin
    hc_d   = hc_q;
    vc_d   = vc_q;
    h_wrap = tick && (hc_q == H_LAST);
    v_wrap = h_wrap && (vc_q == V_LAST);
    if (tick) begin
      hc_d = h_wrap ? '0 : hc_q + CNT_W'(1);
    end
    if (h_wrap) begin
      vc_d = v_wrap ? '0 : vc_q + CNT_W'(1);
    end
  end

  // Reset parks the counters on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q          <= H_LAST;
      vc_q          <= V_LAST;
      vidon_q       <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      vidon_q       <= (hc_d < H_VIS_C) && (vc_d < V_VIS_C);
      hsync_q       <= ((hc_d >= HS_BEG) && (hc_d < HS_END)) ? HS_POL : ~HS_POL;
      vsync_q       <= ((vc_d >= VS_BEG) && (vc_d < VS_END)) ? VS_POL : ~VS_POL;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign vidon       = vidon_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_tick    = tick;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a tiny CLK_DIV=1,
// positive-polarity instance, checked cycle by cycle plus directed timing probes.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] a_hc, a_vc, b_hc, b_vc;
  logic a_vidon, a_hsync, a_vsync, a_pix_tick, a_line_start, a_frame_start;
  logic b_vidon, b_hsync, b_vsync, b_pix_tick, b_line_start, b_frame_start;

  vga_sync_gen dut_a (
    .clk(clk), .rst_n(rst_n), .hc(a_hc), .vc(a_vc), .vidon(a_vidon),
    .hsync(a_hsync), .vsync(a_vsync), .pix_tick(a_pix_tick),
    .line_start(a_line_start), .frame_start(a_frame_start)
  );

  // Tiny timing: H 8+2+3+2 = 15, V 4+1+2+1 = 8, hsync hc 10..12, vsync vc 5..6.
  vga_sync_gen #(
    .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .hc(b_hc), .vc(b_vc), .vidon(b_vidon),
    .hsync(b_hsync), .vsync(b_vsync), .pix_tick(b_pix_tick),
    .line_start(b_line_start), .frame_start(b_frame_start)
  );

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic vidon, hs, vs, pt, ls, fs;
  } obs_t;

  int   checks = 0;
  int   failures = 0;
  int   sb_prints = 0;
  int   e = 0;
  bit   sb_en = 1'b0;
  obs_t qa[$];
  obs_t qb[$];

  // Closed-form expectation from the number of clk edges since reset release.
  function automatic obs_t model(int ed, int d, int hv, int hfp, int hsy, int hbp,
                                 int vv, int vfp, int vsy, int vbp, bit hp, bit vp);
    obs_t o;
    int ht, vt, adv, prv, hcv, vcv, p;
    ht  = hv + hfp + hsy + hbp;
    vt  = vv + vfp + vsy + vbp;
    adv = (ed <= 0) ? 0 : ((d == 1) ? ed - 1 : ed / d);
    prv = (ed <= 1) ? 0 : ((d == 1) ? ed - 2 : (ed - 1) / d);
    if (adv == 0) begin
      hcv = ht - 1;
      vcv = vt - 1;
    end else begin
      p   = adv - 1;
      hcv = p % ht;
      vcv = (p / ht) % vt;
    end
    o.hc    = 11'(hcv);
    o.vc    = 11'(vcv);
    o.pt    = (ed >= 1) && ((ed % d) == d - 1);
    o.ls    = (adv != prv) && (hcv == 0);
    o.fs    = o.ls && (vcv == 0);
    o.vidon = (hcv < hv) && (vcv < vv);
    o.hs    = ((hcv >= hv + hfp) && (hcv < hv + hfp + hsy)) ? hp : ~hp;
    o.vs    = ((vcv >= vv + vfp) && (vcv < vv + vfp + vsy)) ? vp : ~vp;
    return o;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) e = 0;
    else        e = e + 1;
    if (sb_en) begin
      qa.push_back(model(e, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
      qb.push_back(model(e, 1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1));
    end
  end

  always @(negedge clk) begin
    obs_t exp_o, act_o;
    while (qa.size() > 0) begin
      exp_o = qa.pop_front();
      act_o = {a_hc, a_vc, a_vidon, a_hsync, a_vsync, a_pix_tick, a_line_start, a_frame_start};
      checks++;
      if (act_o !== exp_o) begin
        failures++;
        if (sb_prints < 20)
          $display("FAIL sb_a e=%0d got %h expected %h", e, act_o, exp_o);
        sb_prints++;
      end
    end
    while (qb.size() > 0) begin
      exp_o = qb.pop_front();
      act_o = {b_hc, b_vc, b_vidon, b_hsync, b_vsync, b_pix_tick, b_line_start, b_frame_start};
      checks++;
      if (act_o !== exp_o) begin
        failures++;
        if (sb_prints < 20)
          $display("FAIL sb_b e=%0d got %h expected %h", e, act_o, exp_o);
        sb_prints++;
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_a_hc"}, a_hc, 799);
    check({tag, "_a_vc"}, a_vc, 524);
    check({tag, "_a_vidon"}, a_vidon, 0);
    check({tag, "_a_hsync"}, a_hsync, 1);
    check({tag, "_a_vsync"}, a_vsync, 1);
    check({tag, "_a_strobes"}, {a_pix_tick, a_line_start, a_frame_start}, 0);
    check({tag, "_b_hc"}, b_hc, 14);
    check({tag, "_b_vc"}, b_vc, 7);
    check({tag, "_b_syncs"}, {b_hsync, b_vsync}, 0);
  endtask

  initial begin
    int n, vid, hsl, vsh, hsh, bad, found;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sb_en = 1'b1;
    #1 check_reset_outputs("rst");
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    check("first_tick_a", a_pix_tick, 1);
    check("first_tick_hc", a_hc, 799);
    check("div1_tick_b", b_pix_tick, 1);
    @(negedge clk);
    check("origin_hc", a_hc, 0);
    check("origin_vc", a_vc, 0);
    check("origin_vidon", a_vidon, 1);
    check("origin_fs_ls", {a_frame_start, a_line_start}, 3);

    // One full line of the default instance, sampled once per clk.
    n = 0; vid = 0; hsl = 0;
    do begin
      vid += int'(a_vidon);
      hsl += int'(!a_hsync);
      @(negedge clk);
      n++;
    end while (!a_line_start && n < 4000);
    check("line_period_clks", n, 3200);
    check("line_vidon_clks", vid, 2560);
    check("line_hsync_clks", hsl, 384);
    check("line_wrap_vc", a_vc, 1);
    check("line_wrap_hc", a_hc, 0);

    // One full frame of the tiny instance.
    n = 0;
    while (!b_frame_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_fs_seen", b_frame_start, 1);
    n = 0; vid = 0; vsh = 0; hsh = 0; bad = 0;
    do begin
      vid += int'(b_vidon);
      vsh += int'(b_vsync);
      hsh += int'(b_hsync);
      if (b_vidon && b_vc >= 4) bad++;
      @(negedge clk);
      n++;
    end while (!b_frame_start && n < 400);
    check("b_frame_period", n, 120);
    check("b_frame_vidon", vid, 32);
    check("b_frame_vsync_hi", vsh, 30);
    check("b_frame_hsync_hi", hsh, 24);
    check("b_vidon_blank", bad, 0);

    // Asynchronous reset between edges, mid-line.
    n = 0;
    while (a_hc != 300 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("reach_hc300", a_hc, 300);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0; found = 0;
    while (!found && n < 10) begin
      @(negedge clk);
      n++;
      if (a_frame_start) found = 1;
    end
    check("arst_fs_found", found, 1);
    check("arst_fs_clks", n, 4);
    check("arst_fs_hc", a_hc, 0);
    check("arst_fs_vc", a_vc, 0);

    repeat (50) @(negedge clk);
    sb_en = 1'b0;
    @(negedge clk);
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
